// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the memory bridge
//
// Purpose: state encoding, abort data pattern and default wait limit used by
//          mem_bridge and mem_bridge_wdog.
// Ports:   none (package).
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Returned to the core in place of bus data when a read is abandoned.
  localparam logic [31:0] MEMBR_ABORT_DATA = 32'hDEADBEEF;

  // Default number of bus wait cycles tolerated before abandoning a request.
  localparam int MEMBR_TIMEOUT_DEFAULT = 255;

  // Wait counter width: at least 8 bits, wider when the limit needs it.
  function automatic int wdog_width(input int limit);
    return (limit > 255) ? $clog2(limit + 1) : 8;
  endfunction

endpackage

// File: rtl/mem_bridge_wdog.sv
// rtl/mem_bridge_wdog.sv - bus wait-cycle watchdog for the memory bridge
//
// Purpose: counts cycles a bus request waits without bus_ready; flags when the
//          current wait cycle is the TIMEOUT-th one. Used only when
//          MEMBR_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clear   in  zero the counter (held while no request is outstanding)
//   enable  in  count this cycle (request waiting, no bus_ready)
//   expired out this wait cycle reaches the limit
module mem_bridge_wdog
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = MEMBR_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = wdog_width(TIMEOUT);

  logic [CW-1:0] count;

  // count holds the number of wait cycles already elapsed, so the cycle in
  // which count == TIMEOUT-1 is the TIMEOUT-th wait cycle.
  assign expired = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - multicycle controller to shared I/D bus bridge
//
// Purpose: turns the controller's IorD/MemWrite access request into one
//          handshaked bus transaction, stalls the controller until it
//          completes, returns registered read data and flags faults.
//          Optional request timeout: define MEMBR_TIMEOUT_EN.
// Ports:
//   clk, rst (async active-low)
//   cpu_req, IorD, MemWrite          access request from the controller
//   pc_addr, alu_addr, cpu_wdata     fetch address, data address, store data
//   cpu_rdata                        registered read data (IR / MDR source)
//   mem_stall                        controller must hold its state
//   mem_err                          sticky fault (misaligned / timeout)
//   bus_valid, bus_we, bus_addr, bus_wdata, bus_ready, bus_rdata   bus side
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int AW = 32
`ifdef MEMBR_TIMEOUT_EN
  ,
  parameter int TIMEOUT = MEMBR_TIMEOUT_DEFAULT
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          IorD,
  input  logic          MemWrite,
  input  logic [AW-1:0] pc_addr,
  input  logic [AW-1:0] alu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          mem_stall,
  output logic          mem_err,
  output logic          bus_valid,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ready,
  input  logic [31:0]   bus_rdata
);

  state_t        state;
  logic          skip_req;  // set for the IDLE cycle right after DONE
  logic [AW-1:0] sel_addr;
  logic          abort;

  assign sel_addr = IorD ? alu_addr : pc_addr;

  // The controller advances exactly in DONE, so stall everywhere else.
  assign mem_stall = cpu_req && (state != ST_DONE);

`ifdef MEMBR_TIMEOUT_EN
  logic wd_expired;

  mem_bridge_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_REQ),
    .enable ((state == ST_REQ) && !bus_ready),
    .expired(wd_expired)
  );

  assign abort = wd_expired;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      skip_req  <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          skip_req <= 1'b0;
          // The level-sensitive request is still high for the cycle after
          // DONE; skip_req keeps that stale level from starting a new access.
          if (cpu_req && !skip_req) begin
            if (sel_addr[1:0] == 2'b00) begin
              bus_valid <= 1'b1;
              bus_we    <= IorD && MemWrite;
              bus_addr  <= {sel_addr[AW-1:2], 2'b00};
              bus_wdata <= cpu_wdata;
              state     <= ST_REQ;
            end else begin
              mem_err <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end

        ST_REQ: begin
          // The handshake is never withdrawn on cpu_req, only on completion
          // or timeout.
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) begin
              cpu_rdata <= bus_rdata;
            end
            state <= ST_DONE;
          end else if (abort) begin
            bus_valid <= 1'b0;
            mem_err   <= 1'b1;
            if (!bus_we) begin
              cpu_rdata <= MEMBR_ABORT_DATA;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          skip_req <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
